// File: rtl/clock_dec_pipe.sv
// WIDTH-bit, DEPTH-stage delay pipeline with per-stage valid bits.
// The pipeline stalls when io_en is low, io_flush clears every valid bit, and io_count tracks occupancy.
module clock_dec_pipe #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                           myClock,
    input  logic                           myNewReset,
    input  logic                           io_en,
    input  logic                           io_flush,
    input  logic                           io_in_valid,
    input  logic [WIDTH-1:0]               io_in_bits,
    output logic                           io_out_valid,
    output logic [WIDTH-1:0]               io_out_bits,
    output logic [$clog2(DEPTH+1)-1:0]     io_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Shift on advance, hold on stall; flush clears only valid bits and the counter.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q;
        if (io_en) begin
            data_d[0] = io_in_bits;
            vld_d[0]  = io_in_valid;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                data_d[i] = data_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
            cnt_d = cnt_q + CNT_W'(io_in_valid) - CNT_W'(vld_q[DEPTH-1]);
        end
        if (io_flush) begin
            vld_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge myClock or posedge myNewReset) begin
        if (myNewReset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VAL;
            end
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
        end
    end

    assign io_out_bits  = data_q[DEPTH-1];
    assign io_out_valid = vld_q[DEPTH-1];
    assign io_count     = cnt_q;

endmodule

// File: tb/tb_clock_dec_pipe.sv
// Scoreboard bench for clock_dec_pipe: a DEPTH=4 instance for the main scenarios and a DEPTH=1 instance.
module tb_clock_dec_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, flush, in_valid;
    logic [7:0] in_bits;
    logic       out_valid;
    logic [7:0] out_bits;
    logic [2:0] count;

    logic       d1_en, d1_flush, d1_in_valid;
    logic [7:0] d1_in_bits;
    logic       d1_out_valid;
    logic [7:0] d1_out_bits;
    logic [0:0] d1_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q  [$];
    logic [7:0] q1 [$];

    always #5 clk = ~clk;

    clock_dec_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A)) u_dut (
        .myClock      (clk),
        .myNewReset   (rst),
        .io_en        (en),
        .io_flush     (flush),
        .io_in_valid  (in_valid),
        .io_in_bits   (in_bits),
        .io_out_valid (out_valid),
        .io_out_bits  (out_bits),
        .io_count     (count)
    );

    clock_dec_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_dut1 (
        .myClock      (clk),
        .myNewReset   (rst),
        .io_en        (d1_en),
        .io_flush     (d1_flush),
        .io_in_valid  (d1_in_valid),
        .io_in_bits   (d1_in_bits),
        .io_out_valid (d1_out_valid),
        .io_out_bits  (d1_out_bits),
        .io_count     (d1_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic f, input logic v, input logic [7:0] b);
        en       = e;
        flush    = f;
        in_valid = v;
        in_bits  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic v, input logic [7:0] b);
        d1_en       = 1'b1;
        d1_in_valid = v;
        d1_in_bits  = b;
        @(posedge clk);
        #1;
    endtask

    // Departure monitors: a valid output leaves on the coming edge when the enable is high.
    always @(negedge clk) begin
        if (!rst && en && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%0h required=none", out_bits);
            end else begin
                chk("sb_data", 32'(out_bits), 32'(q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && d1_en && d1_out_valid) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb1_unexpected actual=%0h required=none", d1_out_bits);
            end else begin
                chk("sb1_data", 32'(d1_out_bits), 32'(q1.pop_front()));
            end
        end
    end

    int stream_cnt [5] = '{1, 2, 3, 4, 4};
    int bub_cnt    [8] = '{1, 1, 2, 2, 1, 1, 0, 0};
    logic [3:0] bub_v  = 4'b0101;

    initial begin
        rst = 1'b1;
        en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_bits = 8'h00;
        d1_en = 1'b0; d1_flush = 1'b0; d1_in_valid = 1'b0; d1_in_bits = 8'h00;
        #1;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_bits", 32'(out_bits), 32'h5A);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_d1_bits", 32'(d1_out_bits), 32'h00);
        @(negedge clk);
        rst = 1'b0;

        // Streaming 0x01..0x05, then drain.
        for (int i = 0; i < 5; i++) begin
            q.push_back(8'(i + 1));
            step(1'b1, 1'b0, 1'b1, 8'(i + 1));
            chk("stream_count", 32'(count), 32'(stream_cnt[i]));
            if (i == 3) begin
                chk("stream_lat_valid", 32'(out_valid), 32'h1);
                chk("stream_lat_bits", 32'(out_bits), 32'h01);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            chk("drain_count", 32'(count), 32'(3 - i));
        end

        // Stall with a full pipe while offering 0xFF.
        for (int i = 0; i < 4; i++) begin
            q.push_back(8'(8'h10 + i));
            step(1'b1, 1'b0, 1'b1, 8'(8'h10 + i));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'hFF);
            chk("stall_bits", 32'(out_bits), 32'h10);
            chk("stall_valid", 32'(out_valid), 32'h1);
            chk("stall_count", 32'(count), 32'h4);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("stall_drained", 32'(count), 32'h0);

        // Bubbles: valid 1,0,1,0 with data A0..A3.
        q.push_back(8'hA0);
        q.push_back(8'hA2);
        for (int i = 0; i < 8; i++) begin
            if (i < 4) step(1'b1, 1'b0, bub_v[i], 8'(8'hA0 + i));
            else       step(1'b1, 1'b0, 1'b0, 8'h00);
            chk("bubble_count", 32'(count), 32'(bub_cnt[i]));
            if (i == 4) begin
                chk("bubble_bits", 32'(out_bits), 32'hA1);
                chk("bubble_valid", 32'(out_valid), 32'h0);
            end
        end

        // Flush with three tokens inside and a token offered on the flush edge.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'(8'hB0 + i));
        chk("preflush_count", 32'(count), 32'h3);
        step(1'b1, 1'b1, 1'b1, 8'h77);
        chk("flush_count", 32'(count), 32'h0);
        chk("flush_valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            chk("postflush_valid", 32'(out_valid), 32'h0);
            chk("postflush_count", 32'(count), 32'h0);
        end

        // Asynchronous reset between edges with a full pipe.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'(8'hC0 + i));
        en = 1'b0;
        in_valid = 1'b0;
        chk("full_valid", 32'(out_valid), 32'h1);
        chk("full_bits", 32'(out_bits), 32'hC0);
        chk("full_count", 32'(count), 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_bits", 32'(out_bits), 32'h5A);
        chk("arst_count", 32'(count), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("post_arst_count", 32'(count), 32'h0);

        // DEPTH=1 streaming.
        q1.push_back(8'h01);
        step1(1'b1, 8'h01);
        chk("d1_bits0", 32'(d1_out_bits), 32'h01);
        chk("d1_valid0", 32'(d1_out_valid), 32'h1);
        chk("d1_count0", 32'(d1_count), 32'h1);
        q1.push_back(8'h02);
        step1(1'b1, 8'h02);
        chk("d1_bits1", 32'(d1_out_bits), 32'h02);
        chk("d1_count1", 32'(d1_count), 32'h1);
        step1(1'b0, 8'h00);
        chk("d1_valid2", 32'(d1_out_valid), 32'h0);
        chk("d1_count2", 32'(d1_count), 32'h0);
        d1_en = 1'b0;
        step(1'b0, 1'b0, 1'b0, 8'h00);

        chk("sb_empty", 32'(q.size()), 32'h0);
        chk("sb1_empty", 32'(q1.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
